cfg_shift_ctrl: RTL and testbench

Sequencer that loads a parallel configuration word into the serial configuration shift register (32-bit, shifts on rising edge of its clock, din enters q[0], q[i] moves to q[i+1]). It accepts a word over a valid/ready handshake, generates the shift clock and serial data, pulses a latch strobe when the word is in place, and keeps a readback copy of the last committed word. It sits between the Wishbone-side config registers and the SSTL pad configuration chain.

---
 rtl/cfg_shift_pkg.sv | 27 ++
 rtl/cfg_phase_timer.sv | 40 ++++
 rtl/cfg_shift_ctrl.sv | 151 +++++++++++++++
 tb/tb_cfg_shift_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_shift_pkg.sv
// Shared definitions for the configuration-chain sequencer.
// Contents:
//   state_e          sequencer state encoding
//   DEF_WIDTH        default downstream shift-register length
//   DEF_CLK_DIV      default clk cycles per shift-clock half-period
//   done_cycle()     cycle index (after acceptance) of the done pulse
package cfg_shift_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_CLK_DIV = 1;

  // Cycles counted from 0 after the accepting edge; done appears in this cycle.
  // A complete word occupies done_cycle() + 2 cycles back to back.
  function automatic int unsigned done_cycle(input int unsigned width,
                                             input int unsigned clk_div);
    return (2 * width + 1) * clk_div;
  endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Reloadable down-counter that times one shift-clock phase.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset (count -> 0)
//   reload_i     restart a phase: count loads CLK_DIV-1
//   phase_end_o  high in the last cycle of the current phase (count == 0)
module cfg_phase_timer #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic reload_i,
  output logic phase_end_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = CNT_W'(CLK_DIV - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = (cnt_q == '0);

endmodule

// File: rtl/cfg_shift_ctrl.sv
// Loads a parallel configuration word into the serial pad-configuration
// shift register, MSB first, then strobes the latch and updates a readback
// shadow of the committed word.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   load_valid   load_data holds a word to shift
//   load_data    word; bit k lands in downstream q[k]
//   load_ready   idle, word accepted on load_valid
//   busy         shift/latch sequence running
//   done         one-cycle pulse when cfg_q is updated
//   cfg_q        last fully committed word
//   sr_clk       generated shift clock (clk / (2*CLK_DIV))
//   sr_din       serial data, stable CLK_DIV cycles around each sr_clk rise
//   sr_latch     latch strobe after the final shift
module cfg_shift_ctrl
  import cfg_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cfg_q,
  output logic             sr_clk,
  output logic             sr_din,
  output logic             sr_latch
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_e             state_q;
  logic [IDX_W-1:0]   bit_idx_q;
  logic [IDX_W-1:0]   idx_dec;
  logic [WIDTH-1:0]   shadow_q;
  logic [WIDTH-1:0]   cfg_qq;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic               sr_clk_q;
  logic               sr_din_q;
  logic               sr_latch_q;
  logic               phase_end;
  logic               reload;

  assign idx_dec = bit_idx_q - IDX_W'(1);

  // The timer restarts on acceptance and on every phase change, so each
  // SHIFT_LO/SHIFT_HI/LATCH phase lasts exactly CLK_DIV cycles.
  always_comb begin
    reload = 1'b0;
    case (state_q)
      IDLE:                       reload = load_valid && ready_q;
      SHIFT_LO, SHIFT_HI, LATCH:  reload = phase_end;
      default:                    reload = 1'b0;
    endcase
  end

  cfg_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk         (clk),
    .rst         (rst),
    .reload_i    (reload),
    .phase_end_o (phase_end)
  );

  // Outputs are set on the edge entering each state, so they are registered
  // images of the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      shadow_q   <= '0;
      cfg_qq     <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sr_clk_q   <= 1'b0;
      sr_din_q   <= 1'b0;
      sr_latch_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid && ready_q) begin
            shadow_q  <= load_data;
            bit_idx_q <= IDX_W'(WIDTH - 1);
            sr_din_q  <= load_data[WIDTH-1];
            sr_clk_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            sr_clk_q <= 1'b1;
            state_q  <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            sr_clk_q <= 1'b0;
            if (bit_idx_q == '0) begin
              sr_latch_q <= 1'b1;
              state_q    <= LATCH;
            end else begin
              bit_idx_q <= idx_dec;
              sr_din_q  <= shadow_q[idx_dec];
              state_q   <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          if (phase_end) begin
            sr_latch_q <= 1'b0;
            done_q     <= 1'b1;
            cfg_qq     <= shadow_q;
            state_q    <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          sr_clk_q   <= 1'b0;
          sr_latch_q <= 1'b0;
          busy_q     <= 1'b0;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign load_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_q      = cfg_qq;
  assign sr_clk     = sr_clk_q;
  assign sr_din     = sr_din_q;
  assign sr_latch   = sr_latch_q;

endmodule

// File: tb/tb_cfg_shift_ctrl.sv
// Directed bench for cfg_shift_ctrl: default, CLK_DIV=3 and WIDTH=8 instances
// driven in turn, each observed by its own behavioural shift-register model.
module tb_cfg_shift_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- default instance ----------------
  logic        a_valid = 1'b0;
  logic [31:0] a_data  = '0;
  logic        a_ready, a_busy, a_done, a_srclk, a_srdin, a_srlatch;
  logic [31:0] a_cfg;
  logic [31:0] a_model;
  int          a_rises = 0;

  cfg_shift_ctrl u_dut (
    .clk(clk), .rst(rst), .load_valid(a_valid), .load_data(a_data),
    .load_ready(a_ready), .busy(a_busy), .done(a_done), .cfg_q(a_cfg),
    .sr_clk(a_srclk), .sr_din(a_srdin), .sr_latch(a_srlatch)
  );

  always @(posedge a_srclk) begin
    a_model <= {a_model[30:0], a_srdin};
    a_rises <= a_rises + 1;
  end

  // ---------------- CLK_DIV = 3 instance ----------------
  logic        b_valid = 1'b0;
  logic [31:0] b_data  = '0;
  logic        b_ready, b_busy, b_done, b_srclk, b_srdin, b_srlatch;
  logic [31:0] b_cfg;
  logic [31:0] b_model;
  int          b_rises = 0;

  cfg_shift_ctrl #(.CLK_DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .load_valid(b_valid), .load_data(b_data),
    .load_ready(b_ready), .busy(b_busy), .done(b_done), .cfg_q(b_cfg),
    .sr_clk(b_srclk), .sr_din(b_srdin), .sr_latch(b_srlatch)
  );

  always @(posedge b_srclk) begin
    b_model <= {b_model[30:0], b_srdin};
    b_rises <= b_rises + 1;
  end

  // ---------------- WIDTH = 8 instance ----------------
  logic       c_valid = 1'b0;
  logic [7:0] c_data  = '0;
  logic       c_ready, c_busy, c_done, c_srclk, c_srdin, c_srlatch;
  logic [7:0] c_cfg;
  logic [7:0] c_model;
  int         c_rises = 0;

  cfg_shift_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .load_valid(c_valid), .load_data(c_data),
    .load_ready(c_ready), .busy(c_busy), .done(c_done), .cfg_q(c_cfg),
    .sr_clk(c_srclk), .sr_din(c_srdin), .sr_latch(c_srlatch)
  );

  always @(posedge c_srclk) begin
    c_model <= {c_model[6:0], c_srdin};
    c_rises <= c_rises + 1;
  end

  // Handshake on the default instance; returns #1 after the accepting edge.
  task automatic a_start(input logic [31:0] w);
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = w;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_data  = '0;
  endtask

  // Full sequence on the default instance with timing checks.
  task automatic a_full(input logic [31:0] w);
    int r0, lat, dn, rdy, nd;
    r0 = a_rises; lat = -1; dn = -1; rdy = -1; nd = 0;
    a_start(w);
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (n == 0) chk("busy_cyc0", a_busy, 1'b1);
      if (a_srlatch && lat < 0) lat = n;
      if (a_done) begin
        nd++;
        if (dn < 0) dn = n;
      end
      if (a_ready && rdy < 0) rdy = n;
    end
    chk("rises", a_rises - r0, 32);
    chk("model", a_model, w);
    chk("latch_cyc", lat, 64);
    chk("done_cyc", dn, 65);
    chk("done_cnt", nd, 1);
    chk("ready_cyc", rdy, 66);
    chk("cfg_q", a_cfg, w);
  endtask

  initial begin
    int hs, d1, d2, nd, r0, rdybad, dinbad, trans, last_t, runbad, sbad, dn, lat;
    logic [31:0] w;
    logic        bclk [0:209];
    logic        bdin [0:209];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_cfg", a_cfg, 32'h0);
    chk("rst_srclk", a_srclk, 1'b0);
    chk("rst_srdin", a_srdin, 1'b0);
    chk("rst_latch", a_srlatch, 1'b0);
    rst = 1'b0;

    // Single load with defaults
    a_full(32'hA5A50F0F);

    // Reset in cycle 20 while bit 21 is due to rise
    a_start(32'hDEADBEEF);
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (n == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_srclk", a_srclk, 1'b0);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_cfg", a_cfg, 32'h0);
    chk("mid_rst_latch", a_srlatch, 1'b0);
    chk("mid_rst_ready", a_ready, 1'b1);
    nd = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (a_done) nd++;
    end
    chk("mid_rst_no_done", nd, 0);
    a_full(32'h12345678);

    // Toggling load_valid/load_data while busy
    w = 32'h3C5A96E1;
    rdybad = 0; dinbad = 0;
    a_start(w);
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (n < 65) begin
        if (a_ready) rdybad++;
        a_valid = (n % 2) == 1;
        a_data  = $urandom;
      end else begin
        a_valid = 1'b0;
      end
      if (n < 64 && a_srclk && a_srdin !== w[31 - (n - 1) / 2]) dinbad++;
    end
    chk("tog_ready_low", rdybad, 0);
    chk("tog_din_seq", dinbad, 0);
    chk("tog_model", a_model, w);
    chk("tog_cfg", a_cfg, w);
    chk("tog_idle_after", a_busy, 1'b0);

    // Back-to-back with load_valid held
    r0 = a_rises; hs = -1; d1 = -1; d2 = -1;
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    a_data = 32'h00000000;
    for (int n = 0; n < 140; n++) begin
      @(negedge clk);
      if (a_ready && a_valid && hs < 0) hs = n;
      else if (hs >= 0) a_valid = 1'b0;
      if (a_done) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
    end
    a_valid = 1'b0;
    chk("b2b_hs_cyc", hs, 66);
    chk("b2b_done1", d1, 65);
    chk("b2b_done_gap", d2 - d1, 67);
    chk("b2b_rises", a_rises - r0, 64);
    chk("b2b_model", a_model, 32'h0);
    chk("b2b_cfg", a_cfg, 32'h0);

    // CLK_DIV = 3
    r0 = b_rises; dn = -1;
    @(negedge clk);
    b_valid = 1'b1;
    b_data  = 32'h80000001;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    b_data  = '0;
    for (int n = 0; n < 210; n++) begin
      @(negedge clk);
      bclk[n] = b_srclk;
      bdin[n] = b_srdin;
      if (b_done && dn < 0) dn = n;
    end
    trans = 0; last_t = 0; runbad = 0; sbad = 0;
    for (int n = 1; n < 210; n++) begin
      if (bclk[n] != bclk[n-1]) begin
        trans++;
        if (n - last_t != 3) runbad++;
        last_t = n;
      end
    end
    for (int r = 3; r < 200; r++) begin
      if (bclk[r] && !bclk[r-1]) begin
        for (int k = r - 3; k <= r + 2; k++) begin
          if (bdin[k] != bdin[r]) sbad++;
        end
      end
    end
    chk("div3_transitions", trans, 64);
    chk("div3_level_len", runbad, 0);
    chk("div3_setup_hold", sbad, 0);
    chk("div3_rises", b_rises - r0, 32);
    chk("div3_done_cyc", dn, 195);
    chk("div3_model", b_model, 32'h80000001);
    chk("div3_cfg", b_cfg, 32'h80000001);

    // WIDTH = 8
    r0 = c_rises; dn = -1; lat = -1;
    @(negedge clk);
    c_valid = 1'b1;
    c_data  = 8'hC3;
    @(posedge clk);
    #1;
    c_valid = 1'b0;
    c_data  = '0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (c_done && dn < 0) dn = n;
      if (c_srlatch && lat < 0) lat = n;
    end
    chk("w8_rises", c_rises - r0, 8);
    chk("w8_latch_cyc", lat, 16);
    chk("w8_done_cyc", dn, 17);
    chk("w8_model", {24'h0, c_model}, 32'hC3);
    chk("w8_cfg", {24'h0, c_cfg}, 32'hC3);
    chk("w8_ready", c_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
